gain_ramp: RTL and testbench

Gain-setpoint controller driving the `data_gain` input of the audio gain datapath. Accepts a target gain (Q4.12) over a valid/ready handshake, then slews its output linearly toward that target by a programmable step once per sample strobe `ce`, avoiding zipper noise. Also provides a level-sensitive mute with fade-out and fade-in. It sits between the control/register interface and the gain datapath, sharing that datapath's `clk` and `ce`.

---
 rtl/gain_pkg.sv | 17 +
 rtl/gain_ramp_if.sv | 13 +
 rtl/gain_ramp.sv | 110 +++++++++++
 tb/tb_gain_ramp.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gain_pkg.sv
// Shared gain constants (Q4.12) and the gain ramp FSM state type.
package gain_pkg;

    localparam int unsigned GAIN_W     = 16;
    localparam int unsigned GAIN_FBITS = 12;

    localparam int GAIN_UNITY  = 4096;
    localparam int GAIN_HALF   = 2048;
    localparam int GAIN_DOUBLE = 8192;
    localparam int GAIN_MUTE   = 0;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RAMP = 1'b1
    } gain_ramp_state_t;

endpackage

// File: rtl/gain_ramp_if.sv
// Target-gain valid/ready handshake between the register interface and gain_ramp.
interface gain_ramp_if
    import gain_pkg::*;
#(
    parameter int unsigned GWIDTH = GAIN_W
);
    logic signed [GWIDTH-1:0] tgt_gain;
    logic                     tgt_valid;
    logic                     tgt_ready;

    modport master (output tgt_gain, output tgt_valid, input  tgt_ready);
    modport slave  (input  tgt_gain, input  tgt_valid, output tgt_ready);
endinterface

// File: rtl/gain_ramp.sv
// Gain setpoint controller: slews gain_o toward the target by step per ce, with mute fade.
// Optional macro GAIN_RAMP_CLAMP_EN: negative targets are latched as zero.
module gain_ramp
    import gain_pkg::*;
#(
    parameter int unsigned GWIDTH    = GAIN_W,
    parameter int unsigned FBITS     = GAIN_FBITS,
    parameter int unsigned STEP_W    = 12,
    parameter int          INIT_GAIN = 1 << FBITS
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ce,
    gain_ramp_if.slave               tgt_if,
    input  logic [STEP_W-1:0]        step,
    input  logic                     mute,
    output logic signed [GWIDTH-1:0] gain_o,
    output logic                     ramping_o,
    output logic                     done_o
);

    localparam int unsigned DW = GWIDTH + 1;

    gain_ramp_state_t         r_state, w_state_nxt;
    logic signed [GWIDTH-1:0] r_gain, w_gain_nxt;
    logic signed [GWIDTH-1:0] r_tgt, w_tgt_nxt;
    logic                     r_done, w_done_nxt;

    logic                     w_hs;
    logic signed [GWIDTH-1:0] w_tgt_in;
    logic signed [GWIDTH-1:0] w_eff;
    logic signed [DW-1:0]     w_diff;
    logic        [DW-1:0]     w_mag;
    logic        [DW-1:0]     w_step_x;
    logic                     w_last_step;

    assign w_hs = tgt_if.tgt_valid && (r_state == IDLE);

    // Incoming target after optional non-inverting clamp
    always_comb begin
        w_tgt_in = GWIDTH'(tgt_if.tgt_gain);
`ifdef GAIN_RAMP_CLAMP_EN
        if (w_tgt_in[GWIDTH-1]) begin
            w_tgt_in = '0;
        end
`endif
    end

    // Effective target sees the incoming value on the handshake edge, not the stale register
    assign w_eff       = mute ? GWIDTH'(GAIN_MUTE) : (w_hs ? w_tgt_in : r_tgt);
    assign w_diff      = DW'(w_eff) - DW'(r_gain);
    assign w_mag       = w_diff[DW-1] ? DW'(-w_diff) : DW'(w_diff);
    assign w_step_x    = DW'(step);
    assign w_last_step = (step == '0) || (w_mag <= w_step_x);

    always_comb begin
        w_state_nxt = r_state;
        w_gain_nxt  = r_gain;
        w_tgt_nxt   = r_tgt;
        w_done_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_hs) begin
                    w_tgt_nxt = w_tgt_in;
                end
                if (w_eff != r_gain) begin
                    w_state_nxt = RAMP;
                end else if (w_hs) begin
                    w_done_nxt = 1'b1;
                end
            end
            RAMP: begin
                if (ce) begin
                    if (w_last_step) begin
                        w_gain_nxt  = w_eff;
                        w_state_nxt = IDLE;
                        w_done_nxt  = 1'b1;
                    end else if (w_diff[DW-1]) begin
                        w_gain_nxt = r_gain - GWIDTH'(step);
                    end else begin
                        w_gain_nxt = r_gain + GWIDTH'(step);
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_gain  <= GWIDTH'(INIT_GAIN);
            r_tgt   <= GWIDTH'(INIT_GAIN);
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_gain  <= w_gain_nxt;
            r_tgt   <= w_tgt_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign gain_o           = r_gain;
    assign done_o           = r_done;
    assign ramping_o        = (r_state == RAMP);
    assign tgt_if.tgt_ready = (r_state == IDLE);

endmodule

// File: tb/tb_gain_ramp.sv
// Scoreboard bench for gain_ramp: directed test-plan scenarios followed by random traffic.
module tb_gain_ramp;

    logic                clk;
    logic                rst_n;
    logic                ce;
    logic [11:0]         step;
    logic                mute;
    logic signed [15:0]  gain_o;
    logic                ramping_o;
    logic                done_o;

    gain_ramp_if #(.GWIDTH(16)) u_if ();

    gain_ramp u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ce        (ce),
        .tgt_if    (u_if),
        .step      (step),
        .mute      (mute),
        .gain_o    (gain_o),
        .ramping_o (ramping_o),
        .done_o    (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit busy;
        bit rst;
    } st_t;

    int  q_gain[$];
    int  q_done[$];
    st_t q_st[$];

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: current gain, latched target, and whether a slew is in progress
    int m_gain = -100000;
    int m_tgt  = 4096;
    bit m_busy = 1'b0;

    function automatic void chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic int clamp_tgt(input int t);
`ifdef GAIN_RAMP_CLAMP_EN
        return (t < 0) ? 0 : t;
`else
        return t;
`endif
    endfunction

    // Applies one clock edge of the rules to the model, using the inputs the DUT just sampled
    function automatic void model_edge();
        int  eff;
        int  d;
        int  nxt;
        int  s;
        st_t e;
        e.rst = 1'b0;
        if (!rst_n) begin
            if (m_gain != 4096) q_gain.push_back(4096);
            m_gain = 4096;
            m_tgt  = 4096;
            m_busy = 1'b0;
            e.rst  = 1'b1;
        end else if (!m_busy) begin
            if (u_if.tgt_valid) m_tgt = clamp_tgt(int'(u_if.tgt_gain));
            eff = mute ? 0 : m_tgt;
            if (eff != m_gain) m_busy = 1'b1;
            else if (u_if.tgt_valid) q_done.push_back(m_gain);
        end else if (ce) begin
            eff = mute ? 0 : m_tgt;
            d   = eff - m_gain;
            s   = int'(step);
            if (s == 0 || (d < 0 ? -d : d) <= s) begin
                nxt    = eff;
                m_busy = 1'b0;
                q_done.push_back(eff);
            end else begin
                nxt = (d > 0) ? m_gain + s : m_gain - s;
            end
            if (nxt != m_gain) q_gain.push_back(nxt);
            m_gain = nxt;
        end
        e.busy = m_busy;
        q_st.push_back(e);
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic send(input int t);
        u_if.tgt_gain  = 16'(t);
        u_if.tgt_valid = 1'b1;
        tick();
        u_if.tgt_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Monitor: pops expectations whenever the DUT presents a gain change, a done pulse, or a cycle
    logic signed [15:0] last_gain = 'x;
    initial begin
        st_t s;
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (q_st.size() == 0) begin
                chk("state_queue_empty", 1, 0);
            end else begin
                s = q_st.pop_front();
                chk("ramping_o", int'(ramping_o), int'(s.busy));
                chk("tgt_ready", int'(u_if.tgt_ready), int'(!s.busy));
                if (s.rst) begin
                    chk("reset_gain", int'(gain_o), 4096);
                    chk("reset_done", int'(done_o), 0);
                end
            end
            if (gain_o !== last_gain) begin
                if (q_gain.size() == 0) chk("gain_unexpected_change", int'(gain_o), int'(last_gain));
                else                    chk("gain_step", int'(gain_o), q_gain.pop_front());
                last_gain = gain_o;
            end
            if (done_o === 1'b1) begin
                if (q_done.size() == 0) chk("done_unexpected", 1, 0);
                else                    chk("done_gain", int'(gain_o), q_done.pop_front());
            end
        end
    end

    initial begin
        int jump_exp;
        rst_n          = 1'b0;
        ce             = 1'b0;
        step           = '0;
        mute           = 1'b0;
        u_if.tgt_gain  = '0;
        u_if.tgt_valid = 1'b0;
        do_reset();

        // Ramp up 4096 -> 8192 in four steps of 1024
        ce   = 1'b1;
        step = 12'd1024;
        send(8192);
        repeat (5) tick();
        chk("ramp_up_final", int'(gain_o), 8192);

        // Gated ce with a partial last step
        do_reset();
        step = 12'd1000;
        ce   = 1'b0;
        send(2048);
        for (int i = 0; i < 6; i++) begin
            ce = (i % 2 == 0);
            tick();
        end
        ce = 1'b0;
        tick();
        chk("gated_final", int'(gain_o), 2048);

        // Mute mid-ramp, then release
        do_reset();
        ce   = 1'b1;
        step = 12'd1024;
        send(8192);
        tick();
        tick();
        chk("mute_start", int'(gain_o), 6144);
        mute = 1'b1;
        repeat (8) tick();
        chk("mute_final", int'(gain_o), 0);
        mute = 1'b0;
        repeat (10) tick();
        chk("unmute_final", int'(gain_o), 8192);

        // Jump with step 0 to a negative target, then resend the current value
        step = '0;
        send(-4096);
        tick();
`ifdef GAIN_RAMP_CLAMP_EN
        jump_exp = 0;
`else
        jump_exp = -4096;
`endif
        chk("jump_final", int'(gain_o), jump_exp);
        send(jump_exp);
        chk("same_tgt_no_ramp", int'(ramping_o), 0);
        tick();

        // Reset mid-ramp
        do_reset();
        step = 12'd1024;
        send(8192);
        tick();
        tick();
        chk("pre_reset_gain", int'(gain_o), 6144);
        rst_n = 1'b0;
        tick();
        chk("mid_reset_gain", int'(gain_o), 4096);
        chk("mid_reset_ramping", int'(ramping_o), 0);
        rst_n = 1'b1;

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            ce             = ($urandom_range(0, 9) < 7);
            step           = ($urandom_range(0, 3) == 0) ? 12'd0 : 12'($urandom_range(1, 4095));
            u_if.tgt_valid = ($urandom_range(0, 4) == 0);
            u_if.tgt_gain  = ($urandom_range(0, 7) == 0) ? 16'($urandom)
                                                         : 16'(int'($urandom_range(0, 16384)) - 8192);
            if ($urandom_range(0, 29) == 0) mute = ~mute;
            rst_n = ($urandom_range(0, 199) != 0);
            tick();
        end
        rst_n          = 1'b1;
        u_if.tgt_valid = 1'b0;
        mute           = 1'b0;
        ce             = 1'b0;
        tick();
        @(negedge clk);
        #1;
        chk("gain_queue_drained", q_gain.size(), 0);
        chk("done_queue_drained", q_done.size(), 0);
        chk("state_queue_drained", q_st.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
